// File: rtl/shift_sequencer_pkg.sv
// Shared definitions for the shift sequencer and its single-position shifter.
//   - Shift codes used by the request interface and the shifter.
//   - FSM state encoding for the sequencer.
package shift_sequencer_pkg;

  localparam logic [1:0] SH_PASS = 2'b00;  // no shift
  localparam logic [1:0] SH_LSL  = 2'b01;  // left, LSB fill 0
  localparam logic [1:0] SH_LSR  = 2'b10;  // logical right, MSB fill 0
  localparam logic [1:0] SH_ASR  = 2'b11;  // arithmetic right, MSB kept

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/shift_sequencer_shifter.sv
// Combinational single-position shifter.
// Ports:
//   in    - operand
//   shift - shift code (pass / left / logical right / arithmetic right)
//   sout  - operand shifted by at most one position
module shift_sequencer_shifter
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  output logic [WIDTH-1:0] sout
);

  always_comb begin
    sout = in;
    unique case (shift)
      SH_LSL:  sout = {in[WIDTH-2:0], 1'b0};
      SH_LSR:  sout = {1'b0, in[WIDTH-1:1]};
      SH_ASR:  sout = {in[WIDTH-1], in[WIDTH-1:1]};
      default: sout = in;
    endcase
  end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift-by-N controller built around a single-position shifter.
// A request is accepted in IDLE; the shifter is applied once per clock until the
// captured amount is consumed, then the result is presented with a one-cycle done pulse.
// Ports:
//   clk    - rising-edge clock
//   rst_n  - synchronous active-low reset
//   start  - request strobe, only honoured in IDLE
//   in     - operand, captured on acceptance
//   shift  - shift code, captured on acceptance
//   amount - number of single-position shifts, captured on acceptance
//   busy   - high while shifting
//   done   - one-cycle completion pulse
//   result - final value, held until the next completion or reset
module shift_sequencer
  import shift_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned AMT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] in,
  input  logic [1:0]       shift,
  input  logic [AMT_W-1:0] amount,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic [1:0]       code_q, code_d;
  logic [WIDTH-1:0] sout;

  shift_sequencer_shifter #(
    .WIDTH (WIDTH)
  ) u_shifter (
    .in    (work_q),
    .shift (code_q),
    .sout  (sout)
  );

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      code_q   <= SH_PASS;
    end else begin
      state_q  <= state_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
      code_q   <= code_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          // Nothing to shift: skip straight to completion.
          if (amount == '0 || shift == SH_PASS) state_d = StDone;
          else                                  state_d = StShift;
        end
      end
      StShift: begin
        if (count_q == AMT_W'(1)) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath next values.
  always_comb begin
    work_d   = work_q;
    count_d  = count_q;
    code_d   = code_q;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          work_d  = in;
          code_d  = shift;
          count_d = amount;
        end
      end
      StShift: begin
        work_d  = sout;
        count_d = count_q - AMT_W'(1);
      end
      default: ;
    endcase
    // Result register mirrors the working value for the DONE cycle and then holds.
    if (state_d == StDone) result_d = work_d;
  end

  // Outputs.
  always_comb begin
    busy   = (state_q == StShift);
    done   = (state_q == StDone);
    result = result_q;
  end

endmodule
